// File: rtl/vga_sync_gen.sv
// Raster timing source: scan counters, raw syncs, and a latency-matched pipeline that
// lines up hs/vs/de and blanked RGB with pixel data returned by the pattern source.
module vga_sync_gen #(
   parameter int H_VIS    = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_VIS    = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter int SYNC_POL = 1,
   parameter int PIX_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        active,
   output logic        line_start,
   output logic        frame_start,
   input  logic [3:0]  pix_r,
   input  logic [3:0]  pix_g,
   input  logic [3:0]  pix_b,
   output logic        hs,
   output logic        vs,
   output logic        de,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
   localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS_W  = 10'(V_VIS);
   localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0]  VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic        POL      = (SYNC_POL != 0);

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } vid_t;

   localparam vid_t BLANK = '{hs: ~POL, vs: ~POL, de: 1'b0};

   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        x_wrap, y_wrap;
   logic        line_start_q, frame_start_q;
   logic        active_c, hs_raw, vs_raw;
   vid_t        pipe_q [PIX_LAT];
   vid_t        pipe_d [PIX_LAT];
   logic        de_in_last;
   logic [3:0]  r_q, g_q, b_q;

   // ---------------- scan counters ----------------
   always_comb begin
      x_wrap = (x_q == H_LAST);
      y_wrap = (y_q == V_LAST);
      x_d    = x_q + 11'd1;
      y_d    = y_q;
      if (x_wrap) begin
         x_d = 11'd0;
         y_d = y_wrap ? 10'd0 : (y_q + 10'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q           <= 11'd0;
         y_q           <= 10'd0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         // Pulses are only ever set by a step, so they drop on every ce = 0 clock.
         line_start_q  <= ce & x_wrap;
         frame_start_q <= ce & x_wrap & y_wrap;
         if (ce) begin
            x_q <= x_d;
            y_q <= y_d;
         end
      end
   end

   // ---------------- raw timing decode ----------------
   always_comb begin
      active_c = (x_q < H_VIS_W) && (y_q < V_VIS_W);
      hs_raw   = ((x_q >= HS_FIRST) && (x_q <= HS_LAST)) ? POL : ~POL;
      vs_raw   = ((y_q >= VS_FIRST) && (y_q <= VS_LAST)) ? POL : ~POL;
   end

   // ---------------- alignment pipeline ----------------
   always_comb begin
      pipe_d[0] = '{hs: hs_raw, vs: vs_raw, de: active_c};
      for (int i = 1; i < PIX_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      // The RGB register loads on the same step as the last stage, so it looks
      // at the value about to enter that stage.
      de_in_last = pipe_d[PIX_LAT-1].de;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIX_LAT; i++) begin
            pipe_q[i] <= BLANK;
         end
      end else if (ce) begin
         for (int i = 0; i < PIX_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   // ---------------- blanked pixel register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 4'd0;
         g_q <= 4'd0;
         b_q <= 4'd0;
      end else if (ce) begin
         r_q <= de_in_last ? pix_r : 4'd0;
         g_q <= de_in_last ? pix_g : 4'd0;
         b_q <= de_in_last ? pix_b : 4'd0;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign active      = active_c;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign hs          = pipe_q[PIX_LAT-1].hs;
   assign vs          = pipe_q[PIX_LAT-1].vs;
   assign de          = pipe_q[PIX_LAT-1].de;
   assign r           = r_q;
   assign g           = g_q;
   assign b           = b_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for absolute 800x600 timing points, and a
// shrunken raster with PIX_LAT = 3 and negative syncs checked against a step-count model.
module tb_vga_sync_gen;

   // Shrunken raster: 28 x 10 = 280 steps per frame.
   localparam int   SH_VIS = 16, SH_FP = 3, SH_SYNC = 5, SH_BP = 4;
   localparam int   SV_VIS = 5,  SV_FP = 1, SV_SYNC = 2, SV_BP = 2;
   localparam int   SHT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
   localparam int   SVT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
   localparam int   S_LAT = 3;
   localparam logic SP = 1'b0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- full-size instance ----------------
   logic        rst_b, ce_b;
   logic [3:0]  pr_b, pg_b, pb_b;
   logic [10:0] x_b;
   logic [9:0]  y_b;
   logic        act_b, ls_b, fs_b, hs_b, vs_b, de_b;
   logic [3:0]  r_b, g_b, b_b;

   vga_sync_gen dut (
      .clk(clk), .rst(rst_b), .ce(ce_b), .x(x_b), .y(y_b), .active(act_b),
      .line_start(ls_b), .frame_start(fs_b), .pix_r(pr_b), .pix_g(pg_b), .pix_b(pb_b),
      .hs(hs_b), .vs(vs_b), .de(de_b), .r(r_b), .g(g_b), .b(b_b)
   );

   // ---------------- shrunken instance ----------------
   logic        rst_s, ce_s;
   logic [3:0]  pr_s, pg_s, pb_s;
   logic [10:0] x_s;
   logic [9:0]  y_s;
   logic        act_s, ls_s, fs_s, hs_s, vs_s, de_s;
   logic [3:0]  r_s, g_s, b_s;

   vga_sync_gen #(
      .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
      .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
      .SYNC_POL(0), .PIX_LAT(S_LAT)
   ) dut_s (
      .clk(clk), .rst(rst_s), .ce(ce_s), .x(x_s), .y(y_s), .active(act_s),
      .line_start(ls_s), .frame_start(fs_s), .pix_r(pr_s), .pix_g(pg_s), .pix_b(pb_s),
      .hs(hs_s), .vs(vs_s), .de(de_s), .r(r_s), .g(g_s), .b(b_s)
   );

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick_b(input logic rst_v, input logic ce_v);
      rst_b = rst_v;
      ce_b  = ce_v;
      @(posedge clk);
      #1;
   endtask

   // Reference model for the small instance: everything derives from the number of
   // steps since reset, plus the pixel value that was on the bus at each step.
   int         k_s = 0;
   bit         stepped_s = 1'b0;
   logic [11:0] pix_hist [8192];

   task automatic tick_s(input logic rst_v, input logic ce_v, input logic [11:0] pix);
      rst_s = rst_v;
      ce_s  = ce_v;
      {pr_s, pg_s, pb_s} = pix;
      @(posedge clk);
      #1;
      if (rst_v) begin
         k_s = 0;
         stepped_s = 1'b0;
      end else if (ce_v) begin
         k_s++;
         pix_hist[k_s] = pix;
         stepped_s = 1'b1;
      end else begin
         stepped_s = 1'b0;
      end
   endtask

   function automatic logic [38:0] model_s();
      int   xk, yk, xn, yn;
      logic act, ls, fs, hs, vs, de;
      logic [11:0] rgb;
      xk  = k_s % SHT;
      yk  = (k_s / SHT) % SVT;
      act = (xk < SH_VIS) && (yk < SV_VIS);
      ls  = stepped_s && (xk == 0);
      fs  = ls && (yk == 0);
      hs  = ~SP;
      vs  = ~SP;
      de  = 1'b0;
      rgb = 12'h000;
      if (k_s >= S_LAT) begin
         xn = (k_s - S_LAT) % SHT;
         yn = ((k_s - S_LAT) / SHT) % SVT;
         hs = (xn >= SH_VIS + SH_FP && xn < SH_VIS + SH_FP + SH_SYNC) ? SP : ~SP;
         vs = (yn >= SV_VIS + SV_FP && yn < SV_VIS + SV_FP + SV_SYNC) ? SP : ~SP;
         de = (xn < SH_VIS) && (yn < SV_VIS);
         rgb = de ? pix_hist[k_s] : 12'h000;
      end
      return {11'(xk), 10'(yk), act, ls, fs, hs, vs, de, rgb};
   endfunction

   task automatic check_s(input string name);
      chk(name, {x_s, y_s, act_s, ls_s, fs_s, hs_s, vs_s, de_s, r_s, g_s, b_s}, model_s());
   endtask

   // ---------------- full-size vector table ----------------
   typedef struct {
      int          k;
      logic [10:0] x;
      logic [9:0]  y;
      logic        act, ls, fs, hs, vs, de;
      logic [3:0]  r;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx, hs_cnt, de_cnt, f_cnt, blank_bad, n, w;
      logic prev;

      tbl.push_back('{0,    11'd0,    10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1,    11'd1,    10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF});
      tbl.push_back('{800,  11'd800,  10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF});
      tbl.push_back('{801,  11'd801,  10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{840,  11'd840,  10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{841,  11'd841,  10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{968,  11'd968,  10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{969,  11'd969,  10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1055, 11'd1055, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1056, 11'd0,    10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1057, 11'd1,    10'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF});

      rst_b = 1'b1; ce_b = 1'b1;
      pr_b = 4'hF; pg_b = 4'hF; pb_b = 4'hF;
      rst_s = 1'b1; ce_s = 1'b1;
      pr_s = 4'h0; pg_s = 4'h0; pb_s = 4'h0;

      // ---- full-size: reset with ce ignored, then table walk over two lines ----
      tick_b(1'b1, 1'b0);
      tick_b(1'b1, 1'b1);
      tick_b(1'b1, 1'b0);
      chk("rst_hold", {hs_b, vs_b, de_b, r_b, g_b, b_b, ls_b, fs_b}, '0);

      idx = 0; hs_cnt = 0; de_cnt = 0; f_cnt = 0; blank_bad = 0;
      for (int c = 0; c <= 1100; c++) begin
         if (c > 0) tick_b(1'b0, 1'b1);
         if (c >= 1 && c <= 1056) begin
            hs_cnt += int'(hs_b);
            de_cnt += int'(de_b);
            if ({r_b, g_b, b_b} == 12'hFFF) f_cnt++;
         end
         if (!de_b && {r_b, g_b, b_b} != 12'h000) blank_bad++;
         if (idx < tbl.size() && tbl[idx].k == c) begin
            chk($sformatf("tbl_k%0d", c),
                {x_b, y_b, act_b, ls_b, fs_b, hs_b, vs_b, de_b, r_b},
                {tbl[idx].x, tbl[idx].y, tbl[idx].act, tbl[idx].ls, tbl[idx].fs,
                 tbl[idx].hs, tbl[idx].vs, tbl[idx].de, tbl[idx].r});
            idx++;
         end
      end
      chk("tbl_all_visited", idx, tbl.size());
      chk("hs_width_line0", hs_cnt, 128);
      chk("de_per_line", de_cnt, 800);
      chk("rgb_F_per_line", f_cnt, 800);
      chk("rgb_blank_outside_de", blank_bad, 0);

      // ---- full-size: one-clock reset at x = 500 of line 1 ----
      n = 0;
      while (!(x_b == 11'd500 && y_b == 10'd1) && n < 2000) begin
         tick_b(1'b0, 1'b1);
         n++;
      end
      chk("reach_x500", {x_b, y_b}, {11'd500, 10'd1});
      tick_b(1'b1, 1'b1);
      chk("mid_rst", {x_b, y_b, ls_b, fs_b, hs_b, vs_b, de_b, r_b, g_b, b_b}, '0);
      prev = hs_b;
      n = 0;
      while (n < 2000) begin
         tick_b(1'b0, 1'b1);
         n++;
         if (!prev && hs_b) break;
         prev = hs_b;
      end
      chk("hs_rise_after_rst", n, 841);
      w = 0;
      while (hs_b && w < 300) begin
         tick_b(1'b0, 1'b1);
         w++;
      end
      chk("hs_width_after_rst", w, 128);
      rst_b = 1'b1;

      // ---- shrunken raster: randomized ce, pixels and occasional resets ----
      tick_s(1'b1, 1'b1, 12'h000);
      tick_s(1'b1, 1'b0, 12'h000);
      check_s("s_reset");
      for (int i = 0; i < 3000; i++) begin
         tick_s(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 12'($urandom));
         check_s("s_rand");
      end

      // ---- mid-frame reset, then first frame_start a full frame later ----
      n = 0;
      while (!(x_s == 11'd10 && y_s == 10'd3) && n < 600) begin
         tick_s(1'b0, 1'b1, 12'($urandom));
         check_s("s_seek");
         n++;
      end
      chk("s_reach_mid", {x_s, y_s}, {11'd10, 10'd3});
      tick_s(1'b1, 1'b1, 12'hFFF);
      check_s("s_mid_rst");
      chk("s_mid_rst_blank", {x_s, y_s, de_s, r_s, g_s, b_s, hs_s, vs_s}, {27'd0, 2'b11});
      n = 0;
      while (n < 600) begin
         tick_s(1'b0, 1'b1, 12'hFFF);
         check_s("s_to_frame");
         n++;
         if (fs_s) break;
      end
      chk("s_first_frame_start", n, SHT * SVT);

      // ---- ce on every second clock: line period doubles ----
      n = 0;
      while (!ls_s && n < 200) begin
         tick_s(1'b0, n[0], 12'($urandom));
         check_s("s_half_seek");
         n++;
      end
      chk("s_half_found_ls", ls_s, 1'b1);
      n = 0;
      while (n < 200) begin
         tick_s(1'b0, n[0], 12'($urandom));
         check_s("s_half_rate");
         n++;
         if (ls_s) break;
      end
      chk("s_half_line_period", n, 2 * SHT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
